// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces press and release over consecutive scan ticks, and reports each
// accepted key as a one-cycle pulse plus a rolling four-digit history.
module keypad_scanner #(
  parameter int SCAN_DIV       = 200000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  Rows,
  output logic [3:0]  Cols,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [15:0] number
);

  localparam int TICK_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [3:0]        DB_LAST   = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        cols_q, cols_d;
  logic              key_valid_q, key_valid_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_held_q, key_held_d;
  logic [15:0]       number_q, number_d;

  logic              tick;
  logic [3:0]        cnt_inc;
  logic [1:0]        new_row;
  logic [3:0]        new_code;
  logic [3:0]        locked_code;

  // Active-low one-hot pattern for a 2-bit line index (column drive or
  // the row pattern expected while a key in that row is down).
  function automatic logic [3:0] onehot_low(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b1111;
    v[idx] = 1'b0;
    return v;
  endfunction

  // True when exactly one row line is pulled low.
  function automatic logic single_low(input logic [3:0] r);
    return (r == 4'b1110) || (r == 4'b1101) ||
           (r == 4'b1011) || (r == 4'b0111);
  endfunction

  // Index of the single low row line; only meaningful when single_low holds.
  function automatic logic [1:0] low_index(input logic [3:0] r);
    logic [1:0] idx;
    case (r)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Physical keypad legend: row0 = 1 2 3 A, row1 = 4 5 6 B,
  // row2 = 7 8 9 C, row3 = 0 F E D, columns left to right.
  function automatic logic [3:0] key_lookup(input logic [1:0] row,
                                            input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  assign tick        = (tick_cnt_q == TICK_LAST);
  assign cnt_inc     = cnt_q + 4'd1;
  assign new_row     = low_index(Rows);
  assign new_code    = key_lookup(new_row, col_q);
  assign locked_code = key_lookup(row_q, col_q);

  // Next-state logic: scan divider, column stepping and the
  // press/hold/release debounce machine, all evaluated on scan ticks only.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : (tick_cnt_q + TICK_ONE);
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    number_d    = number_q;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (single_low(Rows)) begin
            row_d = new_row;
            if (DB_LAST == 4'd1) begin
              // A single consistent scan is enough: accept on detection.
              state_d     = HELD;
              cnt_d       = 4'd0;
              key_valid_d = 1'b1;
              key_code_d  = new_code;
              number_d    = {number_q[11:0], new_code};
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end else begin
            // No key or an ambiguous multi-row pattern: keep scanning.
            col_d = col_q + 2'd1;
          end
        end

        DEBOUNCE: begin
          if (Rows == onehot_low(row_q)) begin
            if (cnt_inc >= DB_LAST) begin
              state_d     = HELD;
              cnt_d       = 4'd0;
              key_valid_d = 1'b1;
              key_code_d  = locked_code;
              number_d    = {number_q[11:0], locked_code};
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            col_d   = col_q + 2'd1;
          end
        end

        HELD: begin
          // Anything still low in the locked column (including a second
          // key) keeps the press alive without producing a new pulse.
          if (Rows == 4'b1111) begin
            if (DB_LAST == 4'd1) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
              col_d   = col_q + 2'd1;
            end else begin
              state_d = RELEASE;
              cnt_d   = 4'd1;
            end
          end
        end

        RELEASE: begin
          if (Rows == 4'b1111) begin
            if (cnt_inc >= DB_LAST) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
              col_d   = col_q + 2'd1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = HELD;
            cnt_d   = 4'd0;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end

    key_held_d = (state_d == HELD) || (state_d == RELEASE);
    cols_d     = onehot_low(col_d);
  end

  // State and registered outputs; reset overrides every other update.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cnt_q       <= 4'd0;
      cols_q      <= 4'b1110;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      key_held_q  <= 1'b0;
      number_q    <= 16'h0000;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      cols_q      <= cols_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      number_q    <= number_d;
    end
  end

  assign Cols      = cols_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_held  = key_held_q;
  assign number    = number_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a matrix keypad model drives Rows from Cols and a
// set of pressed keys; expectations come from scan-tick arithmetic and a
// queue-style model of the accepted-digit history.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  Rows;
  logic [3:0]  Cols;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] number;

  // Pressed keys, bit index = row*4 + col.
  logic [15:0] keys = '0;
  logic [3:0]  keymap [16];
  logic [3:0]  seq [5];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         pulse_cyc [$];
  logic [3:0] pulse_code [$];
  int         dbl = 0;
  logic       kv_prev = 1'b0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .Rows      (Rows),
    .Cols      (Cols),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .number    (number)
  );

  always #5 clock = ~clock;

  // Matrix keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    Rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (Cols[c] === 1'b0)) Rows[r] = 1'b0;
  end

  // Pulse monitor, sampled mid-cycle.
  always @(negedge clock) begin
    if (key_valid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_code.push_back(key_code);
      if (kv_prev) dbl++;
    end
    kv_prev = (key_valid === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic clear_mon();
    pulse_cyc.delete();
    pulse_code.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    cyc = 0;
    clear_mon();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] code);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++)
      if (keymap[i] == code) idx = i;
    return idx;
  endfunction

  task automatic press(input logic [3:0] code, input int hold, input int gap);
    int idx;
    idx = idx_of(code);
    keys[idx] = 1'b1;
    step(hold);
    keys[idx] = 1'b0;
    step(gap);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cols"}, Cols, 4'hE);
    chk({tag, "_valid"}, key_valid, 1'b0);
    chk({tag, "_held"}, key_held, 1'b0);
    chk({tag, "_code"}, key_code, 4'h0);
    chk({tag, "_number"}, number, 16'h0000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_num;
    logic [3:0]  expc;
    logic [3:0]  code;
    int          acc_cyc;
    int          rel_cyc;
    int          waited;
    int          npulse;

    keymap = '{4'h1, 4'h2, 4'h3, 4'hA,
               4'h4, 4'h5, 4'h6, 4'hB,
               4'h7, 4'h8, 4'h9, 4'hC,
               4'h0, 4'hF, 4'hE, 4'hD};
    seq = '{4'h1, 4'h2, 4'hA, 4'h0, 4'hF};

    // Reset values.
    do_reset();
    chk_reset_vals("reset");

    // Idle scan: column index steps once every SD clocks.
    for (int k = 0; k < 5 * SD; k++) begin
      expc = 4'b1111;
      expc[(k / SD) % 4] = 1'b0;
      chk("idle_cols", Cols, expc);
      step(1);
    end
    chk("idle_no_pulse", pulse_cyc.size(), 0);

    // Clean press of '6' (row1, col2) from cycle 0, released at cycle 40.
    // Tick j falls in cycle SD*j+SD-1 and scans column j%4 while idle.
    do_reset();
    acc_cyc = SD * (2 + DB - 1) + SD;
    rel_cyc = SD * (40 / SD + DB - 1) + SD;
    keys[1*4+2] = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (k == 40) keys[1*4+2] = 1'b0;
      if (k == acc_cyc - 1) chk("press_held_before", key_held, 1'b0);
      if (k == acc_cyc) begin
        chk("press_valid", key_valid, 1'b1);
        chk("press_held", key_held, 1'b1);
        chk("press_code", key_code, 4'h6);
        chk("press_number", number, 16'h0006);
      end
      if (k == acc_cyc + 1) chk("press_valid_drop", key_valid, 1'b0);
      if (k == rel_cyc - 1) chk("release_held_last", key_held, 1'b1);
      if (k == rel_cyc) chk("release_held_clear", key_held, 1'b0);
      step(1);
    end
    chk("press_pulses", pulse_cyc.size(), 1);
    chk("press_pulse_cyc", (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1, acc_cyc);

    // Bounce on '1' (row0, col0): detected at tick 0, lost at tick 2, column
    // moves on and comes back round to col0 at tick 6, accepted at tick 9.
    do_reset();
    keys[0] = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (k == 8)  keys[0] = 1'b0;
      if (k == 12) keys[0] = 1'b1;
      step(1);
    end
    keys[0] = 1'b0;
    step(24);
    chk("bounce_pulses", pulse_cyc.size(), 1);
    chk("bounce_pulse_cyc", (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1, 40);
    chk("bounce_number", number, 16'h0001);

    // Sequence 1,2,A,0,F builds the digit history.
    do_reset();
    exp_num = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      press(seq[i], 48, 24);
      exp_num = {exp_num[11:0], seq[i]};
      chk("seq_pulses", pulse_cyc.size(), i + 1);
      chk("seq_code", key_code, seq[i]);
      chk("seq_number", number, exp_num);
    end

    // Two rows low in one column while idle: ignored.
    do_reset();
    keys[0*4+1] = 1'b1;
    keys[2*4+1] = 1'b1;
    step(48);
    chk("multi_pulses", pulse_cyc.size(), 0);
    chk("multi_held", key_held, 1'b0);
    keys = '0;
    step(8);
    // '5' accepted, then '8' in the same column added while held: no extra pulse.
    keys[1*4+1] = 1'b1;
    step(48);
    keys[2*4+1] = 1'b1;
    step(40);
    keys = '0;
    step(24);
    chk("second_key_pulses", pulse_cyc.size(), 1);
    chk("second_key_code", key_code, 4'h5);
    chk("second_key_number", number, 16'h0005);

    // Reset on the third debounce tick of '2' (row0, col1).
    do_reset();
    press(4'h3, 48, 24);
    chk("pre_reset_number", number, 16'h0003);
    clear_mon();
    waited = 0;
    while (!(Cols == 4'b1101 && (cyc % SD) == 0) && waited < 64) begin
      step(1);
      waited++;
    end
    chk("align_wait", (waited < 64), 1'b1);
    keys[0*4+1] = 1'b1;
    step(2 * SD + SD - 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    cyc = 0;
    chk_reset_vals("mid_reset");
    chk("mid_reset_no_pulse", pulse_cyc.size(), 0);
    acc_cyc = SD * (1 + DB - 1) + SD;
    step(acc_cyc);
    chk("redetect_valid", key_valid, 1'b1);
    chk("redetect_code", key_code, 4'h2);
    keys = '0;
    step(24);
    chk("redetect_pulses", pulse_cyc.size(), 1);
    chk("redetect_pulse_cyc", (pulse_cyc.size() > 0) ? pulse_cyc[0] : -1, acc_cyc);
    chk("redetect_number", number, 16'h0002);

    // Randomized key sequence against the digit-history model.
    do_reset();
    exp_num = 16'h0000;
    npulse = 0;
    repeat (12) begin
      code = 4'($urandom_range(0, 15));
      press(code, $urandom_range(48, 80), $urandom_range(24, 48));
      exp_num = {exp_num[11:0], code};
      npulse++;
      chk("rand_pulses", pulse_cyc.size(), npulse);
      chk("rand_code", key_code, code);
      chk("rand_number", number, exp_num);
      chk("rand_released", key_held, 1'b0);
    end
    chk("pulse_width", dbl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 200000, clock cycles per column step (500 Hz at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive consistent scan ticks required for press and for release; legal range 1..15.
REQ-003 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Rows  input  4  keypad row lines, active-low, externally pulled up; treated as synchronous to clock.
REQ-006 SHALL have port Cols  output  4  keypad column drive, active-low one-hot.
REQ-007 SHALL have port key_valid  output  1  one-cycle pulse per debounced key press.
REQ-008 SHALL have port key_code  output  4  hex value of the last accepted key.
REQ-009 SHALL have port key_held  output  1  high while an accepted key is still held.
REQ-010 SHALL have port number  output  16  last four accepted digits, newest in [3:0].

Function
REQ-011 SHALL run a tick counter 0..SCAN_DIV-1, wrapping to 0; tick is the cycle at terminal count SCAN_DIV-1.
REQ-012 SHALL keep a 2-bit column index; Cols = 4'b1110, 1101, 1011, 0111 for index 0..3.
REQ-013 SHALL sample Rows only on tick cycles, before any column change.
REQ-014 SHALL map (row, col) to key_code: row0 = 1,2,3,A; row1 = 4,5,6,B; row2 = 7,8,9,C; row3 = 0,F,E,D (col0..col3).
REQ-015 SHALL implement FSM states IDLE, DEBOUNCE, HELD, RELEASE.
REQ-016 IDLE: on tick, exactly one Rows bit low -> latch row and column, count = 1, go DEBOUNCE; otherwise advance column index (3 wraps to 0).
REQ-017 IDLE: zero or two-plus low Rows bits on a tick = no key; scanning continues.
REQ-018 Column index SHALL be frozen in DEBOUNCE, HELD, RELEASE.
REQ-019 DEBOUNCE: on tick, Rows equal to latched pattern -> count+1; any other pattern -> IDLE, count = 0, column advances on that tick.
REQ-020 When count reaches DEBOUNCE_SCANS (including the detection tick), the next cycle SHALL show key_valid = 1, key_code updated, number = {number[11:0], key_code}, state HELD.
REQ-021 With DEBOUNCE_SCANS = 1, acceptance SHALL happen on the detection tick (key_valid the following cycle).
REQ-022 key_valid SHALL be high exactly one cycle per accepted press, regardless of hold duration.
REQ-023 HELD: on tick, Rows = 4'b1111 -> RELEASE, count = 1; otherwise stay.
REQ-024 RELEASE: on tick, Rows = 4'b1111 -> count+1; any low bit -> HELD, count = 0; count reaching DEBOUNCE_SCANS -> IDLE, column advances on that tick.
REQ-025 key_held SHALL be 1 in HELD and RELEASE, 0 otherwise.
REQ-026 A second key in the locked column while HELD SHALL NOT generate key_valid; no auto-repeat.
REQ-027 number SHALL shift 4 bits per accepted key; oldest digit discarded; no other write path.
REQ-028 key_code and number SHALL hold their values between accepted keys.

Reset
REQ-029 reset high at a rising edge SHALL set, next cycle: state IDLE, tick counter 0, column index 0, Cols 4'b1110, key_valid 0, key_held 0, key_code 4'h0, number 16'h0000, debounce count 0.
REQ-030 reset mid-DEBOUNCE or mid-HELD SHALL abort with no key_valid; a key still held after reset SHALL be re-detected through the full debounce sequence.
REQ-031 reset SHALL take priority over every other event in the same cycle.

Verification (SCAN_DIV = 4, DEBOUNCE_SCANS = 4)
REQ-032 Idle scan: Rows = 1111 -> Cols cycles 1110,1101,1011,0111,1110 changing every 4 clocks; key_valid never asserted.
REQ-033 Clean press row1/col2 held 40 clocks: key_valid single pulse one cycle after 4th matching tick, key_code = 4'h6, number = 16'h0006, key_held 1 until 4 all-high ticks after release.
REQ-034 Bounce: row low for 2 ticks then high then low -> no key_valid until 4 consecutive matching ticks; exactly one pulse total.
REQ-035 Sequence 1,2,A,0,F: number = 0001, 0012, 012A, 12A0, 2A0F; five key_valid pulses.
REQ-036 Two rows low simultaneously in IDLE -> ignored, scanning continues; second key pressed while HELD -> no extra pulse.
REQ-037 reset asserted on the 3rd debounce tick -> all outputs at reset values, no key_valid; key held -> accepted 4 ticks after scan returns to its column.
